// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: sequences the taps of an NTAPS-tap FIR filter through an
// external multiplier. One product is requested per tap (ISSUE), the block
// waits for a rising edge of i_mul_ready (WAIT), accumulates the product, and
// after the last tap publishes the scaled sum on o_sample (DONE).
// Optional build macro: FIR_TAP_SEQUENCER_SATURATE_EN. Defined, the output
// clamps to the 24-bit signed range. Undefined, the output wraps.
module fir_tap_sequencer #(
    parameter int NTAPS = 8,
    parameter int ACCW  = 40 + $clog2(NTAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [23:0]              i_sample,
    input  logic                     i_coef_we,
    input  logic [$clog2(NTAPS)-1:0] i_coef_addr,
    input  logic [15:0]              i_coef_data,
    output logic                     o_mul_start,
    output logic [23:0]              o_mul_sample,
    output logic [15:0]              o_mul_coefficient,
    input  logic [39:0]              i_mul_product,
    input  logic                     i_mul_ready,
    output logic [23:0]              o_sample,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_drop
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [23:0]            taps  [NTAPS];
    logic [15:0]            coefs [NTAPS];
    logic signed [ACCW-1:0] acc;
    logic [AW-1:0]          index;
    logic [23:0]            sample_hold;
    logic [15:0]            coef_hold;
    logic                   ready_q;
    logic                   ready_rise;
    logic [23:0]            result;

    // Control strobes decoded from the current state.
    logic load;
    logic issue;
    logic accept;
    logic finish;

    assign ready_rise = i_mul_ready & ~ready_q;
    assign o_busy     = (state != IDLE);

    // The operands come straight from the arrays during ISSUE and from the
    // hold registers afterwards, so they stay frozen until the product is in
    // even if a coefficient is rewritten meanwhile.
    assign o_mul_sample      = (state == ISSUE) ? taps[index]  : sample_hold;
    assign o_mul_coefficient = (state == ISSUE) ? coefs[index] : coef_hold;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values; blocking here would create order
    // dependent races between blocks.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control strobes.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        o_mul_start = 1'b0;
        load        = 1'b0;
        issue       = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                o_mul_start = 1'b1;
                issue       = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (ready_rise) begin
                    accept     = 1'b1;
                    state_next = (index == LAST_IDX) ? DONE : ISSUE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay line and coefficient storage.
    // NOTE: both arrays are cleared by reset, so they are built from flops
    // rather than RAM, which has no reset port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                taps[k]  <= '0;
                coefs[k] <= '0;
            end
        end else begin
            if (i_coef_we) begin
                coefs[i_coef_addr] <= i_coef_data;
            end
            if (load) begin
                taps[0] <= i_sample;
                for (int k = 1; k < NTAPS; k++) begin
                    taps[k] <= taps[k-1];
                end
            end
        end
    end

    // Tap index, accumulator, operand hold and ready edge detector.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc         <= '0;
            index       <= '0;
            sample_hold <= '0;
            coef_hold   <= '0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= i_mul_ready;
            if (load) begin
                acc   <= '0;
                index <= '0;
            end
            if (issue) begin
                sample_hold <= taps[index];
                coef_hold   <= coefs[index];
            end
            if (accept) begin
                acc <= acc + {{(ACCW-40){i_mul_product[39]}}, i_mul_product};
                if (index != LAST_IDX) begin
                    index <= index + AW'(1);
                end
            end
        end
    end

    // Scale Q2.38 accumulator back to Q1.23: result bits are acc[38:15].
`ifdef FIR_TAP_SEQUENCER_SATURATE_EN
    // Clamp when the bits above the result sign disagree with it.
    always_comb begin
        if (acc[ACCW-1:38] == {(ACCW-38){acc[38]}}) begin
            result = acc[38:15];
        end else if (acc[ACCW-1]) begin
            result = 24'h800000;
        end else begin
            result = 24'h7FFFFF;
        end
    end
`else
    assign result = acc[38:15];
`endif

    // Output sample register and one-cycle strobes. o_valid rises together
    // with the new o_sample, on the cycle after DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            o_valid <= finish;
            o_drop  <= i_valid && (state != IDLE);
            if (finish) begin
                o_sample <= result;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer. A sum-of-products model of the
// filter predicts every output. A registered multiplier model answers each
// start with a ready pulse three cycles later.
module tb_fir_tap_sequencer;

    localparam int NTAPS = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [23:0] i_sample = '0;
    logic        i_coef_we = 1'b0;
    logic [2:0]  i_coef_addr = '0;
    logic [15:0] i_coef_data = '0;
    logic        o_mul_start;
    logic [23:0] o_mul_sample;
    logic [15:0] o_mul_coefficient;
    logic [39:0] i_mul_product;
    logic        i_mul_ready;
    logic [23:0] o_sample;
    logic        o_valid;
    logic        o_busy;
    logic        o_drop;

    fir_tap_sequencer #(.NTAPS(NTAPS)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_valid           (i_valid),
        .i_sample          (i_sample),
        .i_coef_we         (i_coef_we),
        .i_coef_addr       (i_coef_addr),
        .i_coef_data       (i_coef_data),
        .o_mul_start       (o_mul_start),
        .o_mul_sample      (o_mul_sample),
        .o_mul_coefficient (o_mul_coefficient),
        .i_mul_product     (i_mul_product),
        .i_mul_ready       (i_mul_ready),
        .o_sample          (o_sample),
        .o_valid           (o_valid),
        .o_busy            (o_busy),
        .o_drop            (o_drop)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    // Filter model state.
    logic signed [23:0] m_taps [NTAPS];
    logic signed [15:0] m_coef [NTAPS];
    logic [23:0]        exp_q  [$];

    // Multiplier model state.
    int          mul_cnt = 0;
    logic [23:0] held_s  = '0;
    logic [15:0] held_c  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_out();
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            acc += longint'(m_taps[k]) * longint'(m_coef[k]);
        end
        acc = acc >>> 15;
`ifdef FIR_TAP_SEQUENCER_SATURATE_EN
        if (acc > 64'sd8388607) acc = 64'sd8388607;
        if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
        return acc[23:0];
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NTAPS; k++) begin
            m_taps[k] = '0;
            m_coef[k] = '0;
        end
        exp_q.delete();
    endfunction

    // Registered multiplier: product latched at start, one-cycle ready 3 cycles later.
    always @(posedge i_clk) begin
        i_mul_ready <= 1'b0;
        if (!i_rst_n) begin
            mul_cnt <= 0;
        end else begin
            if (mul_cnt != 0) begin
                mul_cnt <= mul_cnt - 1;
                if (mul_cnt == 1) i_mul_ready <= 1'b1;
            end
            if (o_mul_start) begin
                i_mul_product <= $signed(o_mul_sample) * $signed(o_mul_coefficient);
                held_s        <= o_mul_sample;
                held_c        <= o_mul_coefficient;
                mul_cnt       <= 3;
            end
        end
    end

    // Compare process: every output against the model, operands held while pending.
    always @(negedge i_clk) begin
        if (o_mul_start) n_starts++;
        if (o_valid) begin
            if (exp_q.size() == 0) check("unexpected_o_valid", 64'd1, 64'd0);
            else                   check("model_o_sample", o_sample, exp_q.pop_front());
        end
        if (mul_cnt != 0) begin
            check("hold_mul_sample", o_mul_sample, held_s);
            check("hold_mul_coef", o_mul_coefficient, held_c);
        end
    end

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic write_coef(input int addr, input logic [15:0] data);
        @(posedge i_clk); #1;
        i_coef_we   = 1'b1;
        i_coef_addr = 3'(addr);
        i_coef_data = data;
        m_coef[addr] = data;
        @(posedge i_clk); #1;
        i_coef_we = 1'b0;
    endtask

    // Offer a sample once the block is idle; the model accepts it at the same point.
    task automatic start_sample(input logic [23:0] v);
        bit idle = 0;
        for (int n = 0; n < 500 && !idle; n++) begin
            @(posedge i_clk); #1;
            if (!o_busy) idle = 1;
        end
        check("idle_timeout", 64'(idle), 64'd1);
        i_valid  = 1'b1;
        i_sample = v;
        for (int k = NTAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = v;
        exp_q.push_back(model_out());
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_output(output logic [23:0] val);
        bit got = 0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge i_clk);
            if (o_valid) got = 1;
        end
        check("output_timeout", 64'(got), 64'd1);
        val = o_sample;
    endtask

    task automatic run_sample(input logic [23:0] v, output logic [23:0] val);
        start_sample(v);
        wait_output(val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] r;
        int          s0;
        int          cnt;
        model_clear();

        // Reset state.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_o_sample", o_sample, 24'h0);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_busy", o_busy, 1'b0);
        check("rst_o_drop", o_drop, 1'b0);
        check("rst_mul_start", o_mul_start, 1'b0);
        check("rst_mul_sample", o_mul_sample, 24'h0);
        check("rst_mul_coef", o_mul_coefficient, 16'h0);
        @(posedge i_clk); #1 i_rst_n = 1'b1;

        // Single tap at 0.5.
        write_coef(0, 16'h4000);
        s0 = n_starts;
        run_sample(24'h100000, r);
        check("lit_tap0_half", r, 24'h080000);
        check("mul_start_count", 64'(n_starts - s0), 64'd8);
        repeat (3) @(negedge i_clk);
        check("o_sample_holds", o_sample, 24'h080000);
        check("o_valid_one_cycle", o_valid, 1'b0);

        // Impulse reaches tap 3 after four samples.
        do_reset();
        write_coef(3, 16'h4000);
        run_sample(24'h200000, r); check("lit_tap3_out0", r, 24'h0);
        run_sample(24'h000000, r); check("lit_tap3_out1", r, 24'h0);
        run_sample(24'h000000, r); check("lit_tap3_out2", r, 24'h0);
        run_sample(24'h000000, r); check("lit_tap3_out3", r, 24'h100000);

        // Full scale on every tap: overflow boundary.
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h7FFF);
        for (int k = 0; k < NTAPS; k++) run_sample(24'h7FFFFF, r);
`ifdef FIR_TAP_SEQUENCER_SATURATE_EN
        check("lit_full_scale", r, 24'h7FFFFF);
`else
        check("lit_full_scale", r, 24'hFFF7F8);
`endif

        // Mixed-sign vectors, checked by the model only.
        do_reset();
        write_coef(0, 16'h4000); write_coef(1, 16'hC000);
        write_coef(2, 16'h2000); write_coef(7, 16'h8000);
        run_sample(24'h123456, r);
        run_sample(24'hF00000, r);
        run_sample(24'h7FFFFF, r);
        run_sample(24'h800000, r);

        // Sample offered while busy is dropped.
        do_reset();
        write_coef(0, 16'h4000);
        write_coef(1, 16'h2000);
        start_sample(24'h100000);
        check("busy_during_op", o_busy, 1'b1);
        i_valid  = 1'b1;
        i_sample = 24'h300000;
        @(posedge i_clk); #1 i_valid = 1'b0;
        @(negedge i_clk);
        check("drop_pulse", o_drop, 1'b1);
        @(negedge i_clk);
        check("drop_one_cycle", o_drop, 1'b0);
        wait_output(r);
        check("lit_drop_first", r, 24'h080000);
        run_sample(24'h040000, r);
        check("lit_drop_delay_line", r, 24'h060000);

        // Reset during WAIT of tap 4 aborts the sample and clears state.
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h1000);
        run_sample(24'h111111, r);
        start_sample(24'h222222);
        cnt = 1;
        for (int n = 0; n < 400 && cnt < 5; n++) begin
            @(negedge i_clk);
            if (o_mul_start) cnt++;
        end
        check("reached_tap4", 64'(cnt), 64'd5);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        model_clear();
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (n == 2) i_rst_n = 1'b1;
            if (o_valid) cnt++;
        end
        check("no_valid_after_abort", 64'(cnt), 64'd0);
        check("idle_after_abort", o_busy, 1'b0);
        run_sample(24'h7FFFFF, r);
        check("lit_coefs_cleared", r, 24'h0);
        for (int k = 2; k < NTAPS; k++) write_coef(k, 16'h4000);
        run_sample(24'h000000, r);
        check("lit_taps_cleared", r, 24'h0);

        repeat (5) @(negedge i_clk);
        check("model_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 8, number of filter taps (power of two, 2..64).
REQ-002 SHALL have parameter ACCW, default 40+log2(NTAPS), accumulator width in bits.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  new input sample present.
REQ-006 SHALL have port i_sample  input  24  signed Q1.23 input sample.
REQ-007 SHALL have port i_coef_we  input  1  coefficient write enable.
REQ-008 SHALL have port i_coef_addr  input  log2(NTAPS)  coefficient index.
REQ-009 SHALL have port i_coef_data  input  16  signed Q1.15 coefficient.
REQ-010 SHALL have port o_mul_start  output  1  start strobe to the multiplier.
REQ-011 SHALL have port o_mul_sample  output  24  multiplier sample operand.
REQ-012 SHALL have port o_mul_coefficient  output  16  multiplier coefficient operand.
REQ-013 SHALL have port i_mul_product  input  40  signed multiplier product.
REQ-014 SHALL have port i_mul_ready  input  1  multiplier result valid (level or pulse).
REQ-015 SHALL have port o_sample  output  24  signed filtered output sample.
REQ-016 SHALL have port o_valid  output  1  one-cycle strobe, o_sample updated.
REQ-017 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port o_drop  output  1  one-cycle strobe, input sample rejected.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE with i_valid=1: shift delay line (tap0 <= i_sample, tapk <= tap(k-1)), clear accumulator, index <= 0, go to ISSUE.
REQ-021 ISSUE: o_mul_start=1 for exactly one cycle, with o_mul_sample=tap[index] and o_mul_coefficient=coef[index]; go to WAIT.
REQ-022 Operands SHALL be held stable from ISSUE until the product is accepted.
REQ-023 WAIT: accept i_mul_product only on a 0->1 transition of i_mul_ready (registered edge detect), ignoring a level left high from the previous operation.
REQ-024 On acceptance: accumulator += sign-extended product; if index=NTAPS-1 go to DONE, else index+1, go to ISSUE.
REQ-025 DONE: o_sample <= accumulator arithmetic-shifted right by 15, reduced to 24 bits (see Configuration); o_valid=1 for one cycle; go to IDLE.
REQ-026 o_sample SHALL hold its value between o_valid strobes.
REQ-027 i_valid while not IDLE SHALL be ignored (delay line unchanged) and SHALL pulse o_drop the next cycle.
REQ-028 Coefficient write SHALL take effect in any state, and SHALL be visible to any ISSUE from the next cycle on.
REQ-029 WAIT SHALL have no timeout; the block waits indefinitely for the ready edge.

Reset
REQ-030 With i_rst_n=0 at a clock edge: state IDLE, index 0, accumulator 0, all taps 0, all coefficients 0.
REQ-031 Reset values: o_sample=0, o_valid=0, o_busy=0, o_drop=0, o_mul_start=0, o_mul_sample=0, o_mul_coefficient=0.
REQ-032 Reset mid-operation SHALL abort the current sample; no o_valid is produced for it.

Configuration
REQ-033 Macro FIR_TAP_SEQUENCER_SATURATE_EN defined: shifted accumulator outside [-8388608, 8388607] SHALL clamp to 24'h800000 or 24'h7FFFFF.
REQ-034 Macro FIR_TAP_SEQUENCER_SATURATE_EN undefined: o_sample SHALL be the low 24 bits of the shifted accumulator (wrap-around).

Verification
REQ-035 Bench model multiplier: registered product, ready pulse 3 cycles after start; defaults NTAPS=8.
REQ-036 Reset held 2 cycles -> o_sample=0, o_valid=0, o_busy=0, o_mul_start=0; state IDLE.
REQ-037 coef0=16'h4000, others 0; input 24'h100000 -> one o_valid with o_sample=24'h080000; exactly 8 o_mul_start pulses.
REQ-038 coef3=16'h4000, others 0; inputs 24'h200000,0,0,0 -> outputs 0,0,0,24'h100000.
REQ-039 All coefs 16'h7FFF; 8 inputs of 24'h7FFFFF -> 8th output 24'h7FFFFF with macro, 24'hFFF7F8 without.
REQ-040 i_valid pulsed while o_busy=1 -> o_drop pulses one cycle; the next output equals the value without the extra pulse.
REQ-041 i_rst_n=0 during WAIT of tap 4 -> no o_valid, taps cleared; the following input yields o_sample=0 for all-zero coefs.
